// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner selection for a shared 8:1 mux with bounded grant tenure
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;
  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d, s_q, s_d, win;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d, found, rel, load, keep;
  // k = 8 wraps to ptr itself, so the previous owner is examined last
  always_comb begin
    found = 1'b0;
    win = ptr_q;
    for (int k = 1; k <= 8; k++)
      if (!found && req[3'(ptr_q + 3'(k))]) begin
        found = 1'b1;
        win = 3'(ptr_q + 3'(k));
      end
    rel = !req[s_q] || cnt_q == 4'(MAX_HOLD - 1);
    load = found && (state_q == IDLE || rel);
    keep = state_q == OWN && !rel;
    state_d = load || keep ? OWN : IDLE;
    cnt_d = load ? 4'd0 : keep ? cnt_q + 4'd1 : cnt_q;
    ptr_d = load ? win : ptr_q;
    s_d = load ? win : s_q;
    gnt_d = load ? 8'b1 << win : keep ? gnt_q : 8'h00;
    busy_d = load || keep;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 3'd7;
      cnt_q <= 4'd0;
      s_q <= 3'd0;
      gnt_q <= 8'h00;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
    end
  end
  assign s = s_q;
  assign gnt = gnt_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed and randomized checks of two arbiter instances (hold limits 4 and 1)
module tb_mux8_rr_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] s4, s1;
  logic [7:0] gnt4, gnt1;
  logic       busy4, busy1;
  int tests = 0, fails = 0;
  int own[2], last[2], ten[2], sx[2];
  int lim[2] = '{4, 1};

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .reset(reset), .req(req), .s(s4), .gnt(gnt4), .busy(busy4));
  mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .reset(reset), .req(req), .s(s1), .gnt(gnt1), .busy(busy1));

  // Reference: owner keeps the mux until its request drops or its tenure reaches the limit,
  // then the first requester found cyclically after the last winner takes over.
  task automatic model_step(input int k);
    int w;
    if (reset) begin
      own[k] = -1; last[k] = 7; ten[k] = 0; sx[k] = 0;
    end else if (own[k] < 0 || !req[own[k]] || ten[k] == lim[k]) begin
      w = -1;
      for (int j = 1; j <= 8; j++)
        if (w < 0 && req[(last[k] + j) % 8]) w = (last[k] + j) % 8;
      if (w >= 0) begin
        own[k] = w; last[k] = w; sx[k] = w; ten[k] = 1;
      end else own[k] = -1;
    end else ten[k]++;
  endtask

  function automatic logic [7:0] eg(input int k);
    return own[k] < 0 ? 8'h00 : 8'(1 << own[k]);
  endfunction

  function automatic logic [11:0] ex(input int k);
    return {eg(k), 3'(sx[k]), own[k] >= 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'h00;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if ({gnt4, s4, busy4} !== 12'h000) begin
        fails++;
        $display("FAIL reset_idle cyc %0d: got gnt=%h s=%0d busy=%b want gnt=00 s=0 busy=0", i, gnt4, s4, busy4);
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] want;
    reset = 1'b1; tick(); reset = 1'b0;
    req = 8'h81;
    for (int i = 0; i < 16; i++) begin
      tick();
      want = (i % 8) < 4 ? 8'h01 : 8'h80;
      tests++;
      if (gnt4 !== want || s4 !== (want == 8'h01 ? 3'd0 : 3'd7) || busy4 !== 1'b1) begin
        fails++;
        $display("FAIL alternate cyc %0d: got gnt=%h s=%0d busy=%b want gnt=%h", i, gnt4, s4, busy4, want);
      end
      tests++;
      if ({gnt1, s1, busy1} !== ex(1)) begin
        fails++;
        $display("FAIL alternate_h1 cyc %0d: got %h want %h", i, {gnt1, s1, busy1}, ex(1));
      end
    end
  endtask

  task automatic test_release();
    req = 8'h00; tick();
    req = 8'h08;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req = 8'h00;
      tick();
      tests++;
      if (gnt4 !== (i < 2 ? 8'h08 : 8'h00) || s4 !== 3'd3 || busy4 !== (i < 2)) begin
        fails++;
        $display("FAIL release cyc %0d: got gnt=%h s=%0d busy=%b want gnt=%h s=3", i, gnt4, s4, busy4, i < 2 ? 8'h08 : 8'h00);
      end
    end
  endtask

  task automatic test_rotate_hold1();
    logic [2:0] prev;
    req = 8'hFF;
    tick();
    prev = s1;
    for (int i = 0; i < 16; i++) begin
      tick();
      tests++;
      if (s1 !== 3'(prev + 3'd1) || gnt1 !== 8'b1 << s1 || {gnt1, s1, busy1} !== ex(1)) begin
        fails++;
        $display("FAIL rotate_h1 cyc %0d: got gnt=%h s=%0d prev_s=%0d want %h", i, gnt1, s1, prev, ex(1));
      end
      prev = s1;
    end
  endtask

  task automatic test_hold_regrant();
    req = 8'h00; tick();
    req = 8'h20;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) req = 8'h00;
      tick();
      tests++;
      if (gnt4 !== (i < 10 ? 8'h20 : 8'h00) || busy4 !== (i < 10) || s4 !== 3'd5) begin
        fails++;
        $display("FAIL hold_regrant cyc %0d: got gnt=%h s=%0d busy=%b want gnt=%h", i, gnt4, s4, busy4, i < 10 ? 8'h20 : 8'h00);
      end
    end
  endtask

  task automatic test_reset_mid();
    req = 8'h40;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    tests++;
    if (gnt4 !== 8'h00 || busy4 !== 1'b0 || s4 !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid: got gnt=%h s=%0d busy=%b want gnt=00 s=0 busy=0", gnt4, s4, busy4);
    end
    reset = 1'b0; req = 8'h06;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (gnt4 !== (i < 4 ? 8'h02 : 8'h04) || {gnt4, s4, busy4} !== ex(0)) begin
        fails++;
        $display("FAIL reset_mid_regrant cyc %0d: got gnt=%h s=%0d want gnt=%h", i, gnt4, s4, i < 4 ? 8'h02 : 8'h04);
      end
    end
  endtask

  task automatic test_random();
    int wait4[8];
    for (int i = 0; i < 8; i++) wait4[i] = 0;
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
      tick();
      tests++;
      if ({gnt4, s4, busy4} !== ex(0) || {gnt1, s1, busy1} !== ex(1)) begin
        fails++;
        $display("FAIL random cyc %0d: got h4=%h h1=%h want h4=%h h1=%h", i, {gnt4, s4, busy4}, {gnt1, s1, busy1}, ex(0), ex(1));
      end
      for (int r = 0; r < 8; r++) begin
        wait4[r] = (reset || !req[r] || gnt4[r]) ? 0 : wait4[r] + 1;
        if (wait4[r] > 7 * 4 + 1) begin
          tests++; fails++;
          $display("FAIL starvation req %0d waited %0d cycles, limit %0d", r, wait4[r], 7 * 4 + 1);
          wait4[r] = 0;
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_release();
    test_rotate_hold1();
    test_hold_regrant();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
